// File: rtl/ctrl_decode_pipe_pkg.sv
// rtl/ctrl_decode_pipe_pkg.sv - opcode/funct/ALU constants and control-vector types for the decode pipe
package ctrl_decode_pipe_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_SLTI  = 6'h0A;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  typedef struct packed {
    logic       reg_write;
    logic       mem_to_reg;
    logic       mem_write;
    logic       alu_src;
    logic       reg_dst;
    logic [2:0] alu;
    logic       branch;
    logic       branch_ne;
    logic       jump;
    logic       ext_zero;
    logic       illegal;
  } dec_ctrl_t;

  typedef struct packed {
    logic       reg_write;
    logic       mem_to_reg;
    logic       mem_write;
    logic       alu_src;
    logic       reg_dst;
    logic [2:0] alu;
  } e_ctrl_t;

  typedef struct packed {
    logic reg_write;
    logic mem_to_reg;
    logic mem_write;
  } m_ctrl_t;

  typedef struct packed {
    logic reg_write;
    logic mem_to_reg;
  } w_ctrl_t;

  function automatic dec_ctrl_t mk_ctrl(input logic rw, input logic mr, input logic mw,
                                        input logic as, input logic rd, input logic [2:0] alu);
    dec_ctrl_t c;
    c            = '0;
    c.reg_write  = rw;
    c.mem_to_reg = mr;
    c.mem_write  = mw;
    c.alu_src    = as;
    c.reg_dst    = rd;
    c.alu        = alu;
    return c;
  endfunction

endpackage

// File: rtl/ctrl_decode_pipe_main_decoder.sv
// rtl/ctrl_decode_pipe_main_decoder.sv - combinational opcode/funct to D-stage control vector
module main_decoder
  import ctrl_decode_pipe_pkg::*;
#(
  parameter int IMM_LOGIC = 1
) (
  input  logic [5:0] opcode_i,
  input  logic [5:0] funct_i,
  output dec_ctrl_t  ctrl_o
);

  dec_ctrl_t illegal_c;

  always_comb begin
    illegal_c         = '0;
    illegal_c.illegal = 1'b1;
  end

  always_comb begin
    ctrl_o = '0;
    unique case (opcode_i)
      OP_RTYPE: begin
        unique case (funct_i)
          FN_ADD:  ctrl_o = mk_ctrl(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, ALU_ADD);
          FN_SUB:  ctrl_o = mk_ctrl(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, ALU_SUB);
          FN_AND:  ctrl_o = mk_ctrl(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, ALU_AND);
          FN_OR:   ctrl_o = mk_ctrl(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, ALU_OR);
          FN_SLT:  ctrl_o = mk_ctrl(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, ALU_SLT);
          default: ctrl_o = illegal_c;
        endcase
      end
      OP_ADDI: ctrl_o = mk_ctrl(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, ALU_ADD);
      OP_LW:   ctrl_o = mk_ctrl(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, ALU_ADD);
      OP_SW:   ctrl_o = mk_ctrl(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, ALU_ADD);
      OP_BEQ: begin
        ctrl_o        = mk_ctrl(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, ALU_SUB);
        ctrl_o.branch = 1'b1;
      end
      OP_BNE: begin
        ctrl_o           = mk_ctrl(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, ALU_SUB);
        ctrl_o.branch_ne = 1'b1;
      end
      OP_J: begin
        ctrl_o      = '0;
        ctrl_o.jump = 1'b1;
      end
      // Immediate logic ops decode only when the core is built with them.
      OP_ANDI: begin
        if (IMM_LOGIC != 0) begin
          ctrl_o          = mk_ctrl(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, ALU_AND);
          ctrl_o.ext_zero = 1'b1;
        end else begin
          ctrl_o = illegal_c;
        end
      end
      OP_ORI: begin
        if (IMM_LOGIC != 0) begin
          ctrl_o          = mk_ctrl(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, ALU_OR);
          ctrl_o.ext_zero = 1'b1;
        end else begin
          ctrl_o = illegal_c;
        end
      end
      OP_SLTI: begin
        if (IMM_LOGIC != 0) ctrl_o = mk_ctrl(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, ALU_SLT);
        else                ctrl_o = illegal_c;
      end
      default: ctrl_o = illegal_c;
    endcase
  end

endmodule

// File: rtl/ctrl_decode_pipe.sv
// rtl/ctrl_decode_pipe.sv - main decoder plus D/E, E/M, M/W control registers and illegal counter
module ctrl_decode_pipe
  import ctrl_decode_pipe_pkg::*;
#(
  parameter int ALU_CTRL_W = 3,
  parameter int IMM_LOGIC  = 1,
  parameter int ILL_CNT_W  = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [5:0]            opcodeD,
  input  logic [5:0]            functD,
  input  logic                  enE,
  input  logic                  flushE,
  output logic                  branchD,
  output logic                  branchNeD,
  output logic                  jumpD,
  output logic                  extZeroD,
  output logic                  illegalD,
  output logic                  regWriteE,
  output logic                  memToRegE,
  output logic                  memWriteE,
  output logic                  ALUSrcE,
  output logic                  regDstE,
  output logic [ALU_CTRL_W-1:0] ALUControlE,
  output logic                  regWriteM,
  output logic                  memToRegM,
  output logic                  memWriteM,
  output logic                  regWriteW,
  output logic                  memToRegW,
  output logic [ILL_CNT_W-1:0]  illCount
);

  localparam logic [ILL_CNT_W-1:0] ILL_MAX = {ILL_CNT_W{1'b1}};

  dec_ctrl_t             dec_d;
  e_ctrl_t               e_d, e_q;
  m_ctrl_t               m_d, m_q;
  w_ctrl_t               w_d, w_q;
  logic [ILL_CNT_W-1:0]  ill_d, ill_q;
  logic                  accept_e;

  main_decoder #(
    .IMM_LOGIC(IMM_LOGIC)
  ) u_main_decoder (
    .opcode_i(opcodeD),
    .funct_i (functD),
    .ctrl_o  (dec_d)
  );

  assign branchD   = dec_d.branch;
  assign branchNeD = dec_d.branch_ne;
  assign jumpD     = dec_d.jump;
  assign extZeroD  = dec_d.ext_zero;
  assign illegalD  = dec_d.illegal;

  // An instruction is accepted into E only on a real load, not a flush or a stall.
  assign accept_e = enE && !flushE;

  always_comb begin
    e_d = e_q;
    if (flushE) begin
      e_d = '0;
    end else if (enE) begin
      e_d.reg_write  = dec_d.reg_write;
      e_d.mem_to_reg = dec_d.mem_to_reg;
      e_d.mem_write  = dec_d.mem_write;
      e_d.alu_src    = dec_d.alu_src;
      e_d.reg_dst    = dec_d.reg_dst;
      e_d.alu        = dec_d.alu;
    end
  end

  always_comb begin
    m_d.reg_write  = e_q.reg_write;
    m_d.mem_to_reg = e_q.mem_to_reg;
    m_d.mem_write  = e_q.mem_write;
    w_d.reg_write  = m_q.reg_write;
    w_d.mem_to_reg = m_q.mem_to_reg;
  end

  always_comb begin
    ill_d = ill_q;
    if (accept_e && dec_d.illegal && (ill_q != ILL_MAX)) begin
      ill_d = ill_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      e_q   <= '0;
      m_q   <= '0;
      w_q   <= '0;
      ill_q <= '0;
    end else begin
      e_q   <= e_d;
      m_q   <= m_d;
      w_q   <= w_d;
      ill_q <= ill_d;
    end
  end

  assign regWriteE   = e_q.reg_write;
  assign memToRegE   = e_q.mem_to_reg;
  assign memWriteE   = e_q.mem_write;
  assign ALUSrcE     = e_q.alu_src;
  assign regDstE     = e_q.reg_dst;
  assign ALUControlE = ALU_CTRL_W'(e_q.alu);
  assign regWriteM   = m_q.reg_write;
  assign memToRegM   = m_q.mem_to_reg;
  assign memWriteM   = m_q.mem_write;
  assign regWriteW   = w_q.reg_write;
  assign memToRegW   = w_q.mem_to_reg;
  assign illCount    = ill_q;

endmodule
